regfile_mp_sb: RTL and testbench

- Parametrised multi-port register file for the pipelined CPU core.
- Generalises the 2R/1W register file to:
  - NUM_RD read ports and two write ports (A = ALU writeback, B = load writeback);
  - configurable width/depth and stack-pointer reset value;
  - a pending-write scoreboard that lets decode stall on unresolved load destinations.
- Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

---
 rtl/regfile_mp_sb.sv | 96 +++++++++
 tb/tb_regfile_mp_sb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with dual writeback ports and a pending-load scoreboard.
// Define REGFILE_MP_BYPASS_EN for same-cycle write-through on reads.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int SP_INDEX = 29,
  parameter logic [31:0] SP_INIT = 32'h00000400
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_a,
  input  logic [ADDR_W-1:0]        wa_a,
  input  logic [DATA_W-1:0]        wd_a,
  input  logic                     we_b,
  input  logic [ADDR_W-1:0]        wa_b,
  input  logic [DATA_W-1:0]        wd_b,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic                     sb_flush,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [DATA_W-1:0] SP_VAL = DATA_W'(SP_INIT);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wr_a;
  logic              wr_b;

  assign wr_a = we_a && (wa_a != '0);
  assign wr_b = we_b && (wa_b != '0);

  // Port B is written last so it wins a same-index collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= (i == SP_INDEX && i != 0) ? SP_VAL : '0;
    end else begin
      if (wr_a) regs[wa_a] <= wd_a;
      if (wr_b) regs[wa_b] <= wd_b;
    end
  end

  always_comb begin
    pend_nxt = pend;
    if (sb_flush) begin
      pend_nxt = '0;
    end else begin
      if (wr_a) pend_nxt[wa_a] = 1'b0;
      if (wr_b) pend_nxt[wa_b] = 1'b0;
      if (sb_set && sb_addr != '0)
        pend_nxt[sb_addr] = 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    assign idx = ra[g*ADDR_W +: ADDR_W];
`ifdef REGFILE_MP_BYPASS_EN
    logic hit_a;
    logic hit_b;
    assign hit_a = reset && wr_a && (wa_a == idx);
    assign hit_b = reset && wr_b && (wa_b == idx);
    assign rd[g*DATA_W +: DATA_W] = hit_b ? wd_b :
                                    hit_a ? wd_a : regs[idx];
    assign rd_pend[g] = pend[idx] && !(hit_a || hit_b);
`else
    assign rd[g*DATA_W +: DATA_W] = regs[idx];
    assign rd_pend[g] = pend[idx];
`endif
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed test-plan steps plus
// randomized traffic against an array-based reference model.
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        we_a, we_b;
  logic [4:0]  wa_a, wa_b;
  logic [31:0] wd_a, wd_b;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rd_pend;
  logic        sb_set, sb_flush;
  logic [4:0]  sb_addr;
  logic [5:0]  pend_cnt;

  int total = 0;
  int bad = 0;

  logic [31:0] mreg [32];
  bit          mpend [32];

  regfile_mp_sb dut (
    .clk(clk), .reset(reset),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .ra(ra), .rd(rd), .rd_pend(rd_pend),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .sb_flush(sb_flush), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mreg[i] = '0;
      mpend[i] = 1'b0;
    end
    mreg[29] = 32'h400;
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(mpend[i]);
    return n;
  endfunction

  function automatic bit bp_hit(logic [4:0] idx);
`ifdef REGFILE_MP_BYPASS_EN
    return (we_a && wa_a != 0 && wa_a == idx) ||
           (we_b && wa_b != 0 && wa_b == idx);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_rd(logic [4:0] idx);
    if (bp_hit(idx))
      return (we_b && wa_b != 0 && wa_b == idx) ? wd_b : wd_a;
    return mreg[idx];
  endfunction

  task automatic check_reads();
    for (int p = 0; p < 2; p++) begin
      logic [4:0] idx;
      idx = ra[p*5 +: 5];
      chk($sformatf("rd%0d[%0d]", p, idx), rd[p*32 +: 32], exp_rd(idx));
      chk($sformatf("rd_pend%0d[%0d]", p, idx), 32'(rd_pend[p]),
          32'(mpend[idx] && !bp_hit(idx)));
    end
  endtask

  task automatic model_edge();
    if (we_a && wa_a != 0) mreg[wa_a] = wd_a;
    if (we_b && wa_b != 0) mreg[wa_b] = wd_b;
    if (sb_flush) begin
      for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
    end else begin
      if (we_a && wa_a != 0) mpend[wa_a] = 1'b0;
      if (we_b && wa_b != 0) mpend[wa_b] = 1'b0;
      if (sb_set && sb_addr != 0) mpend[sb_addr] = 1'b1;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    check_reads();
    @(posedge clk);
    model_edge();
    #1;
    chk("pend_cnt", 32'(pend_cnt), 32'(model_cnt()));
    @(negedge clk);
  endtask

  task automatic idle();
    we_a = 0; wa_a = 0; wd_a = 0;
    we_b = 0; wa_b = 0; wd_b = 0;
    sb_set = 0; sb_addr = 0; sb_flush = 0;
  endtask

  initial begin
    idle();
    ra = '0;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    ra = {5'd0, 5'd29};
    #1;
    chk("rst_cnt", 32'(pend_cnt), 32'd0);
    chk("rst_sp", rd[31:0], 32'h400);
    chk("rst_r0", rd[63:32], 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // register 0 is hardwired
    we_a = 1; wa_a = 0; wd_a = 32'hFFFF_FFFF; ra = {5'd1, 5'd0};
    cycle();
    idle(); #1;
    chk("r0_zero", rd[31:0], 32'h0);

    // dual write, same index: B wins
    we_a = 1; wa_a = 5; wd_a = 32'h11;
    we_b = 1; wa_b = 5; wd_b = 32'h22; ra = {5'd0, 5'd5};
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("dual_bp", rd[31:0], 32'h22);
`else
    chk("dual_old", rd[31:0], 32'h0);
`endif
    cycle();
    idle(); #1;
    chk("dual_wr", rd[31:0], 32'h22);

    // write-through on read port 1
    we_a = 1; wa_a = 7; wd_a = 32'hABCD; ra = {5'd7, 5'd5};
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("bp_same", rd[63:32], 32'hABCD);
`else
    chk("bp_same", rd[63:32], 32'h0);
`endif
    cycle();
    idle(); #1;
    chk("bp_next", rd[63:32], 32'hABCD);

    // scoreboard set / clear by load writeback
    sb_set = 1; sb_addr = 3; cycle();
    sb_addr = 4; cycle();
    idle(); ra = {5'd4, 5'd3}; #1;
    chk("sb_cnt2", 32'(pend_cnt), 32'd2);
    chk("sb_pend3", 32'(rd_pend[0]), 32'd1);
    we_b = 1; wa_b = 3; wd_b = 32'h55; cycle();
    idle(); #1;
    chk("sb_cnt1", 32'(pend_cnt), 32'd1);
    chk("sb_clr3", 32'(rd_pend[0]), 32'd0);

    // set wins over same-cycle write; flush beats set
    sb_set = 1; sb_addr = 9; we_a = 1; wa_a = 9; wd_a = 32'h99;
    cycle();
    idle(); ra = {5'd4, 5'd9}; #1;
    chk("coll_cnt", 32'(pend_cnt), 32'd2);
    chk("coll_p9", 32'(rd_pend[0]), 32'd1);
    sb_flush = 1; sb_set = 1; sb_addr = 10; cycle();
    idle(); #1;
    chk("flush_cnt", 32'(pend_cnt), 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      we_a = 1'($urandom_range(0, 1));
      wa_a = 5'($urandom);
      wd_a = $urandom;
      we_b = 1'($urandom_range(0, 1));
      wa_b = ($urandom_range(0, 3) == 0) ? wa_a : 5'($urandom);
      wd_b = $urandom;
      sb_set = ($urandom_range(0, 3) != 0);
      sb_addr = ($urandom_range(0, 5) == 0) ? wa_a : 5'($urandom);
      sb_flush = ($urandom_range(0, 23) == 0);
      ra = 10'($urandom);
      cycle();
    end

    // fill everything, mark 6 pending, then reset between edges
    idle(); sb_flush = 1; cycle();
    idle();
    for (int i = 1; i < 32; i++) begin
      we_a = 1; wa_a = 5'(i); wd_a = $urandom | 32'h1;
      cycle();
    end
    idle();
    for (int i = 1; i <= 6; i++) begin
      sb_set = 1; sb_addr = 5'(i); cycle();
    end
    idle(); ra = {5'd5, 5'd29}; #1;
    chk("pre_cnt", 32'(pend_cnt), 32'd6);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_cnt", 32'(pend_cnt), 32'd0);
    chk("mid_sp", rd[31:0], 32'h400);
    chk("mid_r5", rd[63:32], 32'h0);
    chk("mid_pend", 32'(rd_pend), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ra = {5'd1, 5'd3};
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
